// File: rtl/pps_ctrl_pkg.sv
// Shared types and constants for the 1PPS discipline controller.
// The derived widths below are for the default configuration; modules re-derive them from their own parameters.
package pps_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        UPDATE  = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    localparam int CNT_BITS_DEF   = 28;
    localparam int FILT_SHIFT_DEF = 4;
    localparam int ACC_BITS       = CNT_BITS_DEF + FILT_SHIFT_DEF;
    localparam int ERR_BITS       = CNT_BITS_DEF + 1;
    localparam int REJ_MAX        = 255;

endpackage

// File: rtl/pps_exp_filter.sv
// Integer exponential filter: acc = acc - acc/N + F, N = 2^FILT_SHIFT.
// A seed request loads acc = F*N so the output starts exactly at the first sample.
module pps_exp_filter #(
    parameter int CNT_BITS   = 28,
    parameter int FILT_SHIFT = 4
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                enable,
    input  logic                seed,
    input  logic [CNT_BITS-1:0] sample,
    output logic [CNT_BITS-1:0] filt_out,
    output logic [CNT_BITS-1:0] filt_next
);

    localparam int ACC_W = CNT_BITS + FILT_SHIFT;

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] sample_ext;

    assign sample_ext = {{FILT_SHIFT{1'b0}}, sample};

    // Subtract the decayed share first so the intermediate never exceeds acc.
    always_comb begin
        if (seed) begin
            acc_next = {sample, {FILT_SHIFT{1'b0}}};
        end else begin
            acc_next = (acc_reg - (acc_reg >> FILT_SHIFT)) + sample_ext;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_reg <= '0;
        end else if (enable) begin
            acc_reg <= acc_next;
        end
    end

    assign filt_out  = acc_reg[ACC_W-1:FILT_SHIFT];
    assign filt_next = acc_next[ACC_W-1:FILT_SHIFT];

endmodule

// File: rtl/pps_discipline_ctrl.sv
// Sequences 1PPS count captures through window check, filter update and result handshake,
// tracking lock, rejected samples and loss of PPS (holdover).
module pps_discipline_ctrl
    import pps_ctrl_pkg::*;
#(
    parameter int CNT_BITS   = 28,
    parameter int FILT_SHIFT = 4,
    parameter int NOMINAL    = 26000000,
    parameter int TOL        = 2000,
    parameter int LOCK_TOL   = 16,
    parameter int LOCK_CNT   = 8
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [CNT_BITS-1:0] count_in,
    input  logic                count_stb,
    input  logic                res_ready,
    output logic                res_valid,
    output logic [CNT_BITS-1:0] filt_out,
    output logic [CNT_BITS:0]   err_out,
    output logic                locked,
    output logic                holdover,
    output logic [7:0]          reject_cnt,
    output logic                overrun
);

    localparam int ERR_W    = CNT_BITS + 1;
    localparam int WD_LIMIT = NOMINAL + TOL + 1;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    localparam int RUN_W    = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_BITS-1:0] WIN_LO     = CNT_BITS'(NOMINAL - TOL);
    localparam logic [CNT_BITS-1:0] WIN_HI     = CNT_BITS'(NOMINAL + TOL);
    localparam logic [CNT_BITS-1:0] LOCK_TOL_C = CNT_BITS'(LOCK_TOL);
    localparam logic [ERR_W-1:0]    NOM_E      = ERR_W'(NOMINAL);
    localparam logic [WD_W-1:0]     WD_LIMIT_C = WD_W'(WD_LIMIT);
    localparam logic [WD_W-1:0]     WD_PRE_C   = WD_W'(WD_LIMIT - 1);
    localparam logic [RUN_W-1:0]    LOCK_C     = RUN_W'(LOCK_CNT);
    localparam logic [7:0]          REJ_MAX_C  = 8'(REJ_MAX);

    state_t              state_reg, state_next;
    logic [CNT_BITS-1:0] sample_reg;
    logic                seeded_reg;
    logic [RUN_W-1:0]    run_reg;
    logic [RUN_W-1:0]    run_inc;
    logic [WD_W-1:0]     wd_reg;
    logic                locked_reg, holdover_reg, overrun_reg;
    logic [7:0]          reject_reg;
    logic [ERR_W-1:0]    err_reg;

    logic                take_sample, filt_en, overrun_set;
    logic                in_window, qualifies;
    logic [CNT_BITS-1:0] filt_cur, filt_next, lock_diff;

    pps_exp_filter #(
        .CNT_BITS  (CNT_BITS),
        .FILT_SHIFT(FILT_SHIFT)
    ) u_filter (
        .clk      (clk),
        .nreset   (nreset),
        .enable   (filt_en),
        .seed     (!seeded_reg),
        .sample   (sample_reg),
        .filt_out (filt_cur),
        .filt_next(filt_next)
    );

    assign in_window = (sample_reg >= WIN_LO) && (sample_reg <= WIN_HI);
    assign lock_diff = (sample_reg >= filt_cur) ? (sample_reg - filt_cur) : (filt_cur - sample_reg);
    assign qualifies = !seeded_reg || (lock_diff <= LOCK_TOL_C);
    assign run_inc   = (run_reg == LOCK_C) ? run_reg : run_reg + 1'b1;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        take_sample = 1'b0;
        filt_en     = 1'b0;
        overrun_set = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (count_stb) begin
                    take_sample = 1'b1;
                    state_next  = CHECK;
                end
            end
            CHECK: begin
                overrun_set = count_stb;
                state_next  = in_window ? UPDATE : IDLE;
            end
            UPDATE: begin
                overrun_set = count_stb;
                filt_en     = 1'b1;
                state_next  = PUBLISH;
            end
            PUBLISH: begin
                // A new strobe always wins the slot; it is an overrun only if the result was not taken.
                if (count_stb) begin
                    take_sample = 1'b1;
                    overrun_set = !res_ready;
                    state_next  = CHECK;
                end else if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sample_reg   <= '0;
            seeded_reg   <= 1'b0;
            run_reg      <= '0;
            wd_reg       <= '0;
            locked_reg   <= 1'b0;
            holdover_reg <= 1'b0;
            overrun_reg  <= 1'b0;
            reject_reg   <= '0;
            err_reg      <= '0;
        end else begin
            overrun_reg <= overrun_set;
            if (take_sample) begin
                sample_reg <= count_in;
            end
            if (count_stb) begin
                wd_reg <= '0;
            end else if (wd_reg != WD_LIMIT_C) begin
                wd_reg <= wd_reg + 1'b1;
            end

            if (state_reg == CHECK) begin
                if (in_window) begin
                    holdover_reg <= 1'b0;
                end else begin
                    if (reject_reg != REJ_MAX_C) begin
                        reject_reg <= reject_reg + 8'd1;
                    end
                    locked_reg <= 1'b0;
                    run_reg    <= '0;
                end
            end

            if (state_reg == UPDATE) begin
                seeded_reg <= 1'b1;
                err_reg    <= {1'b0, filt_next} - NOM_E;
                if (qualifies) begin
                    run_reg <= run_inc;
                    if (run_inc == LOCK_C) begin
                        locked_reg <= 1'b1;
                    end
                end else begin
                    run_reg    <= '0;
                    locked_reg <= 1'b0;
                end
            end

            // Watchdog expiry: entered on the cycle the count reaches its limit.
            if (!count_stb && (wd_reg == WD_PRE_C)) begin
                holdover_reg <= 1'b1;
                locked_reg   <= 1'b0;
                run_reg      <= '0;
            end
        end
    end

    assign res_valid  = (state_reg == PUBLISH);
    assign filt_out   = filt_cur;
    assign err_out    = err_reg;
    assign locked     = locked_reg;
    assign holdover   = holdover_reg;
    assign reject_cnt = reject_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_pps_discipline_ctrl.sv
// Directed bench for pps_discipline_ctrl with NOMINAL=1000, TOL=10, FILT_SHIFT=2, LOCK_TOL=2, LOCK_CNT=4.
module tb_pps_discipline_ctrl;

    localparam int CNT_BITS = 28;

    logic                clk = 1'b0;
    logic                nreset = 1'b0;
    logic [CNT_BITS-1:0] count_in = '0;
    logic                count_stb = 1'b0;
    logic                res_ready = 1'b0;
    logic                res_valid;
    logic [CNT_BITS-1:0] filt_out;
    logic [CNT_BITS:0]   err_out;
    logic                locked;
    logic                holdover;
    logic [7:0]          reject_cnt;
    logic                overrun;

    int vectors = 0;
    int miscompares = 0;

    pps_discipline_ctrl #(
        .CNT_BITS  (CNT_BITS),
        .FILT_SHIFT(2),
        .NOMINAL   (1000),
        .TOL       (10),
        .LOCK_TOL  (2),
        .LOCK_CNT  (4)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .count_in  (count_in),
        .count_stb (count_stb),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .filt_out  (filt_out),
        .err_out   (err_out),
        .locked    (locked),
        .holdover  (holdover),
        .reject_cnt(reject_cnt),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are read 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        count_stb = 1'b0;
        res_ready = 1'b0;
        nreset    = 1'b0;
        step();
        step();
        nreset = 1'b1;
    endtask

    // Strobe one sample; returns 1 ns after the capturing edge (state CHECK).
    task automatic pulse(input int f);
        count_in  = CNT_BITS'(f);
        count_stb = 1'b1;
        step();
        count_stb = 1'b0;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #2;
        vectors++;
        if ({res_valid, locked, holdover, overrun} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000", {res_valid, locked, holdover, overrun});
        end
        vectors++;
        if (filt_out !== 28'd0 || err_out !== 29'd0 || reject_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_data: got filt=%0d err=%0d rej=%0d expected 0/0/0", filt_out, err_out, reject_cnt);
        end
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_filter();
        do_reset();
        pulse(1000);
        step();
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_t2: got res_valid=%b expected 0", res_valid);
        end
        step();
        vectors++;
        if (res_valid !== 1'b1 || filt_out !== 28'd1000 || err_out !== 29'd0) begin
            miscompares++;
            $display("FAIL seed: got v=%b filt=%0d err=%0d expected 1/1000/0", res_valid, filt_out, err_out);
        end
        accept();
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL handshake_idle: got res_valid=%b expected 0", res_valid);
        end
        pulse(1008);
        step();
        step();
        vectors++;
        if (res_valid !== 1'b1 || filt_out !== 28'd1002 || err_out !== 29'd2) begin
            miscompares++;
            $display("FAIL update_1008: got v=%b filt=%0d err=%0d expected 1/1002/2", res_valid, filt_out, err_out);
        end
        accept();
        pulse(1020);
        step();
        step();
        vectors++;
        if (res_valid !== 1'b0 || reject_cnt !== 8'd1 || filt_out !== 28'd1002) begin
            miscompares++;
            $display("FAIL reject_1020: got v=%b rej=%0d filt=%0d expected 0/1/1002", res_valid, reject_cnt, filt_out);
        end
        pulse(1010);
        step();
        step();
        vectors++;
        if (res_valid !== 1'b1 || filt_out !== 28'd1004 || err_out !== 29'd4) begin
            miscompares++;
            $display("FAIL window_hi_1010: got v=%b filt=%0d err=%0d expected 1/1004/4", res_valid, filt_out, err_out);
        end
        accept();
        pulse(990);
        step();
        step();
        vectors++;
        if (res_valid !== 1'b1 || filt_out !== 28'd1000 || err_out !== 29'd0) begin
            miscompares++;
            $display("FAIL window_lo_990: got v=%b filt=%0d err=%0d expected 1/1000/0", res_valid, filt_out, err_out);
        end
        accept();
        pulse(989);
        step();
        step();
        vectors++;
        if (res_valid !== 1'b0 || reject_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL reject_989: got v=%b rej=%0d expected 0/2", res_valid, reject_cnt);
        end
        $display("test_filter done");
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            pulse(1000);
            step();
            step();
            vectors++;
            if (locked !== (i == 4)) begin
                miscompares++;
                $display("FAIL lock_sample%0d: got locked=%b expected %b", i, locked, (i == 4));
            end
            accept();
        end
        pulse(1005);
        step();
        step();
        vectors++;
        if (locked !== 1'b0 || filt_out !== 28'd1001 || err_out !== 29'd1) begin
            miscompares++;
            $display("FAIL unlock_1005: got locked=%b filt=%0d err=%0d expected 0/1001/1", locked, filt_out, err_out);
        end
        accept();
        $display("test_lock done");
    endtask

    task automatic test_holdover();
        do_reset();
        pulse(1000);
        step();
        step();
        accept();
        repeat (1007) step();
        vectors++;
        if (holdover !== 1'b0) begin
            miscompares++;
            $display("FAIL holdover_early: got %b expected 0 at 1010 cycles", holdover);
        end
        step();
        vectors++;
        if (holdover !== 1'b1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL holdover_entry: got ho=%b locked=%b expected 1/0 at 1011 cycles", holdover, locked);
        end
        pulse(995);
        step();
        vectors++;
        if (holdover !== 1'b0) begin
            miscompares++;
            $display("FAIL holdover_exit: got %b expected 0", holdover);
        end
        step();
        vectors++;
        if (res_valid !== 1'b1 || filt_out !== 28'd998 || err_out !== 29'(-2)) begin
            miscompares++;
            $display("FAIL holdover_keep_acc: got v=%b filt=%0d err=%h expected 1/998/1ffffffe", res_valid, filt_out, err_out);
        end
        accept();
        $display("test_holdover done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse(1000);
        step();
        step();
        vectors++;
        if (res_valid !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: got v=%b ovr=%b expected 1/0", res_valid, overrun);
        end
        pulse(1004);
        vectors++;
        if (overrun !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_publish: got ovr=%b v=%b expected 1/0", overrun, res_valid);
        end
        step();
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_pulse_len: got %b expected 0", overrun);
        end
        step();
        vectors++;
        if (res_valid !== 1'b1 || filt_out !== 28'd1001) begin
            miscompares++;
            $display("FAIL overrun_new_result: got v=%b filt=%0d expected 1/1001", res_valid, filt_out);
        end
        accept();
        pulse(1000);
        pulse(1009);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_check_drop: got %b expected 1", overrun);
        end
        step();
        vectors++;
        if (res_valid !== 1'b1 || filt_out !== 28'd1000) begin
            miscompares++;
            $display("FAIL dropped_sample: got v=%b filt=%0d expected 1/1000", res_valid, filt_out);
        end
        res_ready = 1'b1;
        pulse(1002);
        res_ready = 1'b0;
        vectors++;
        if (overrun !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stb_with_ready: got ovr=%b v=%b expected 0/0", overrun, res_valid);
        end
        step();
        step();
        vectors++;
        if (res_valid !== 1'b1 || filt_out !== 28'd1001) begin
            miscompares++;
            $display("FAIL stb_with_ready_result: got v=%b filt=%0d expected 1/1001", res_valid, filt_out);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_publish();
        #2;
        nreset = 1'b0;
        #1;
        vectors++;
        if (res_valid !== 1'b0 || filt_out !== 28'd0 || err_out !== 29'd0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b filt=%0d err=%0d expected 0/0/0", res_valid, filt_out, err_out);
        end
        step();
        nreset = 1'b1;
        pulse(1006);
        step();
        step();
        vectors++;
        if (res_valid !== 1'b1 || filt_out !== 28'd1006 || err_out !== 29'd6) begin
            miscompares++;
            $display("FAIL reseed_after_reset: got v=%b filt=%0d err=%0d expected 1/1006/6", res_valid, filt_out, err_out);
        end
        accept();
        $display("test_reset_mid_publish done");
    endtask

    initial begin
        test_reset();
        test_filter();
        test_lock();
        test_holdover();
        test_back_to_back();
        test_reset_mid_publish();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
